// File: rtl/spi_flash_responder.sv
// spi_flash_responder
//   Minimal SPI NOR flash emulator (mode 0, MSB first, 24-bit address).
//   SPI pins are oversampled in the PCLK domain. READ (0x03), PROGRAM (0x02),
//   READ ID (0x9F), READ STATUS (0x05), WRITE ENABLE (0x06) and WRITE DISABLE
//   (0x04) are mapped onto a simple synchronous byte memory port.
//
// Ports
//   PCLK, PRESET        clock, synchronous active-high reset
//   SPI_SCLK/SS/SDI     SPI inputs from the master (asynchronous to PCLK)
//   SPI_SDO, SPI_SDO_OE master-in data and its pad output enable
//   MEM_ADDR            byte address for both strobes
//   MEM_RD, MEM_RDATA   read strobe; MEM_RDATA is valid the cycle after MEM_RD
//   MEM_WR, MEM_WDATA   write strobe with its data
//
// Memory port contract: MEM_RD and MEM_WR are single-cycle strobes, never
// high together; MEM_ADDR (and MEM_WDATA for writes) are valid while the
// strobe is high. There is no back-pressure, the memory must accept every
// strobe and return read data exactly one cycle after MEM_RD.
module spi_flash_responder #(
  parameter int          ADDR_WIDTH  = 16,
  parameter logic [23:0] JEDEC_ID    = 24'hBF2541,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  SPI_SCLK,
  input  logic                  SPI_SS,
  input  logic                  SPI_SDI,
  output logic                  SPI_SDO,
  output logic                  SPI_SDO_OE,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  output logic                  MEM_RD,
  input  logic [7:0]            MEM_RDATA,
  output logic                  MEM_WR,
  output logic [7:0]            MEM_WDATA
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_RD_DATA, S_WR_DATA, S_ID, S_STATUS, S_IGNORE
  } state_t;

  // ---------------------------------------------------------------------
  // Synchronisers and edge detection. These flops are deliberately not
  // reset so that the synced SS level is meaningful during PRESET and no
  // false SS edge appears when reset releases.
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q,   ss_sync_d;
  logic [SYNC_STAGES-1:0] sdi_sync_q,  sdi_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   ss_prev_q,   ss_prev_d;

  logic sclk_s, ss_s, sdi_s;
  logic sclk_rise, sclk_fall, ss_fall, ss_rise;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], SPI_SCLK};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0],   SPI_SS};
    sdi_sync_d  = {sdi_sync_q[SYNC_STAGES-2:0],  SPI_SDI};
    sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    ss_s        = ss_sync_q[SYNC_STAGES-1];
    sdi_s       = sdi_sync_q[SYNC_STAGES-1];
    sclk_prev_d = sclk_s;
    ss_prev_d   = ss_s;
    sclk_rise   = sclk_s & ~sclk_prev_q;
    sclk_fall   = ~sclk_s & sclk_prev_q;
    ss_fall     = ~ss_s & ss_prev_q;
    ss_rise     = ss_s & ~ss_prev_q;
  end

  always_ff @(posedge PCLK) begin
    sclk_sync_q <= sclk_sync_d;
    ss_sync_q   <= ss_sync_d;
    sdi_sync_q  <= sdi_sync_d;
    sclk_prev_q <= sclk_prev_d;
    ss_prev_q   <= ss_prev_d;
  end

  // ---------------------------------------------------------------------
  // Protocol FSM and datapath
  // ---------------------------------------------------------------------
  state_t                state_q,     state_d;
  logic [4:0]            bit_cnt_q,   bit_cnt_d;
  logic [22:0]           shift_q,     shift_d;    // incoming bits, newest in [0]
  logic [23:0]           out_sr_q,    out_sr_d;   // outgoing bits, next in [23]
  logic                  sdo_q,       sdo_d;
  logic                  oe_q,        oe_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
  logic [7:0]            mem_wdata_q, mem_wdata_d;
  logic                  mem_rd_q,    mem_rd_d;
  logic                  mem_wr_q,    mem_wr_d;
  logic                  rd_vld_q,    rd_vld_d;   // MEM_RDATA valid this cycle
  logic                  wel_q,       wel_d;
  logic                  is_prog_q,   is_prog_d;  // current address phase is a program

  logic [7:0]  opcode;
  logic [23:0] addr_full;
  logic [7:0]  status_byte;
  logic        drive_state;

  always_comb begin
    opcode      = {shift_q[6:0], sdi_s};
    addr_full   = {shift_q, sdi_s};
    status_byte = {6'b0, wel_q, 1'b0};

    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    out_sr_d    = out_sr_q;
    sdo_d       = sdo_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    rd_vld_d    = mem_rd_q;
    wel_d       = wel_q;
    is_prog_d   = is_prog_q;

    // A write strobe uses the current address; step it afterwards.
    if (mem_wr_q) mem_addr_d = mem_addr_q + ADDR_WIDTH'(1);
    // Read data lands well before the next SCLK fall (phases >= 4 PCLK).
    if (rd_vld_q) out_sr_d = {MEM_RDATA, 16'h0000};

    case (state_q)
      S_IDLE: begin
        if (ss_fall) begin
          state_d   = S_CMD;
          bit_cnt_d = 5'd0;
        end
      end
      S_CMD: begin
        if (sclk_rise) begin
          shift_d   = {shift_q[21:0], sdi_s};
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd7) begin
            bit_cnt_d = 5'd0;
            case (opcode)
              8'h03: begin state_d = S_ADDR; is_prog_d = 1'b0; end
              8'h02: begin
                is_prog_d = 1'b1;
                state_d   = wel_q ? S_ADDR : S_IGNORE;
              end
              8'h9F: begin state_d = S_ID; out_sr_d = JEDEC_ID; end
              8'h05: begin state_d = S_STATUS; out_sr_d = {status_byte, 16'h0000}; end
              8'h06: begin state_d = S_IGNORE; wel_d = 1'b1; end
              8'h04: begin state_d = S_IGNORE; wel_d = 1'b0; end
              default: state_d = S_IGNORE;
            endcase
          end
        end
      end
      S_ADDR: begin
        if (sclk_rise) begin
          shift_d   = {shift_q[21:0], sdi_s};
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd23) begin
            bit_cnt_d  = 5'd0;
            mem_addr_d = addr_full[ADDR_WIDTH-1:0];
            if (is_prog_q) begin
              state_d = S_WR_DATA;
            end else begin
              state_d  = S_RD_DATA;
              mem_rd_d = 1'b1;
            end
          end
        end
      end
      S_RD_DATA: begin
        if (sclk_rise) begin
          bit_cnt_d = bit_cnt_q + 5'd1;
          // Last bit of a byte: prefetch the next one.
          if (bit_cnt_q == 5'd7) begin
            bit_cnt_d  = 5'd0;
            mem_addr_d = mem_addr_q + ADDR_WIDTH'(1);
            mem_rd_d   = 1'b1;
          end
        end
        if (sclk_fall) begin
          sdo_d    = out_sr_q[23];
          out_sr_d = {out_sr_q[22:0], 1'b0};
        end
      end
      S_WR_DATA: begin
        if (sclk_rise) begin
          shift_d   = {shift_q[21:0], sdi_s};
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd7) begin
            bit_cnt_d   = 5'd0;
            mem_wr_d    = 1'b1;
            mem_wdata_d = opcode;  // same bit slice: last 8 bits received
          end
        end
      end
      S_ID: begin
        // Zeros shift in behind the ID, so SDO reads 0 after the third byte.
        if (sclk_fall) begin
          sdo_d    = out_sr_q[23];
          out_sr_d = {out_sr_q[22:0], 1'b0};
        end
      end
      S_STATUS: begin
        if (sclk_rise) begin
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd7) begin
            bit_cnt_d = 5'd0;
            out_sr_d  = {status_byte, 16'h0000};
          end
        end
        if (sclk_fall) begin
          sdo_d    = out_sr_q[23];
          out_sr_d = {out_sr_q[22:0], 1'b0};
        end
      end
      S_IGNORE: ;
      default: state_d = S_IDLE;
    endcase

    // Deselect ends every frame; a partial byte is simply dropped.
    if (ss_rise) begin
      state_d = S_IDLE;
      if (state_q == S_WR_DATA || (state_q == S_ADDR && is_prog_q)) wel_d = 1'b0;
    end

    drive_state = (state_d == S_ID) || (state_d == S_STATUS) || (state_d == S_RD_DATA);
    oe_d        = drive_state;
    if (!drive_state) sdo_d = 1'b0;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      // A frame already in progress is ignored until SS rises.
      state_q     <= ss_s ? S_IDLE : S_IGNORE;
      bit_cnt_q   <= 5'd0;
      shift_q     <= 23'd0;
      out_sr_q    <= 24'd0;
      sdo_q       <= 1'b0;
      oe_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'd0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      rd_vld_q    <= 1'b0;
      wel_q       <= 1'b0;
      is_prog_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      out_sr_q    <= out_sr_d;
      sdo_q       <= sdo_d;
      oe_q        <= oe_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      rd_vld_q    <= rd_vld_d;
      wel_q       <= wel_d;
      is_prog_q   <= is_prog_d;
    end
  end

  assign SPI_SDO    = sdo_q;
  assign SPI_SDO_OE = oe_q;
  assign MEM_ADDR   = mem_addr_q;
  assign MEM_RD     = mem_rd_q;
  assign MEM_WR     = mem_wr_q;
  assign MEM_WDATA  = mem_wdata_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Bench for spi_flash_responder: drives SPI frames from tasks, models the
// flash at transaction level (reference memory, WEL bit, JEDEC id) and
// checks memory strobes in a per-cycle compare process.
module tb_spi_flash_responder;

  localparam int HALF = 6;   // PCLK cycles per SCLK phase
  localparam int SYNC = 2;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        preset = 1'b1;
  logic        spi_sclk = 1'b0, spi_ss = 1'b1, spi_sdi = 1'b0;
  logic        spi_sdo, spi_sdo_oe;
  logic [15:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [7:0]  mem_rdata = 8'h00, mem_wdata;

  always #5 clk = ~clk;

  spi_flash_responder #(.ADDR_WIDTH(16), .JEDEC_ID(24'hBF2541), .SYNC_STAGES(SYNC)) dut (
    .PCLK(clk), .PRESET(preset),
    .SPI_SCLK(spi_sclk), .SPI_SS(spi_ss), .SPI_SDI(spi_sdi),
    .SPI_SDO(spi_sdo), .SPI_SDO_OE(spi_sdo_oe),
    .MEM_ADDR(mem_addr), .MEM_RD(mem_rd), .MEM_RDATA(mem_rdata),
    .MEM_WR(mem_wr), .MEM_WDATA(mem_wdata)
  );

  // Memory attached to the DUT
  logic [7:0] mem [0:65535];
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
    if (mem_wr) mem[mem_addr] <= mem_wdata;
  end

  // ---------------- model state / scoreboard ----------------
  logic [7:0]  ref_mem [0:65535];
  logic        wel_m;
  logic [23:0] jedec_m = 24'hBF2541;
  logic [15:0] exp_rd_q[$];
  logic [23:0] exp_wr_q[$];   // {addr, data}
  logic [7:0]  last_rx[$];

  int n_vec = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- compare process ----------------
  logic rd_prev = 1'b0, wr_prev = 1'b0;
  logic [23:0] wr_exp;
  always @(negedge clk) begin
    if (chk_en) begin
      check("rd_wr_exclusive", {31'd0, mem_rd & mem_wr}, 32'd0);
      check("sdo_low_without_oe", {31'd0, spi_sdo & ~spi_sdo_oe}, 32'd0);
      if (mem_rd) begin
        check("mem_rd_single_cycle", {31'd0, rd_prev}, 32'd0);
        if (exp_rd_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL mem_rd_unexpected: got rd at 0x%0h, want no read", mem_addr);
        end else begin
          check("mem_rd_addr", {16'd0, mem_addr}, {16'd0, exp_rd_q.pop_front()});
        end
      end
      if (mem_wr) begin
        check("mem_wr_single_cycle", {31'd0, wr_prev}, 32'd0);
        if (exp_wr_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL mem_wr_unexpected: got wr 0x%0h@0x%0h, want no write", mem_wdata, mem_addr);
        end else begin
          wr_exp = exp_wr_q.pop_front();
          check("mem_wr_addr_data", {8'd0, mem_addr, mem_wdata}, {8'd0, wr_exp});
        end
      end
    end
    rd_prev = mem_rd;
    wr_prev = mem_wr;
  end

  // ---------------- driver tasks ----------------
  task automatic spi_bit(input logic b, output logic r);
    spi_sdi = b;
    repeat (HALF) @(negedge clk);
    spi_sclk = 1'b1;
    r = spi_sdo;              // master samples on the rising edge
    repeat (HALF) @(negedge clk);
    spi_sclk = 1'b0;
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], r);
      rx[i] = r;
    end
  endtask

  task automatic ss_low();
    last_rx.delete();
    spi_ss = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic ss_high();
    repeat (HALF) @(negedge clk);
    spi_ss = 1'b1;
    repeat (SYNC + 2) @(negedge clk);
    check("oe_after_ss_rise", {31'd0, spi_sdo_oe}, 32'd0);
    repeat (8) @(negedge clk);
  endtask

  task automatic send_addr(input logic [23:0] a);
    logic [7:0] rx;
    xfer(a[23:16], rx);
    xfer(a[15:8], rx);
    xfer(a[7:0], rx);
  endtask

  // ---------------- transaction-level model tasks ----------------
  task automatic do_id();
    logic [7:0] rx;
    ss_low();
    xfer(8'h9F, rx);
    check("id_oe", {31'd0, spi_sdo_oe}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      xfer(8'h00, rx);
      last_rx.push_back(rx);
      check("id_byte", {24'd0, rx}, (i < 3) ? ((jedec_m >> (8 * (2 - i))) & 32'hFF) : 32'd0);
    end
    ss_high();
  endtask

  task automatic do_status(input int n);
    logic [7:0] rx;
    ss_low();
    xfer(8'h05, rx);
    check("status_oe", {31'd0, spi_sdo_oe}, 32'd1);
    for (int i = 0; i < n; i++) begin
      xfer(8'h00, rx);
      last_rx.push_back(rx);
      check("status_byte", {24'd0, rx}, {24'd0, 6'd0, wel_m, 1'b0});
    end
    ss_high();
  endtask

  task automatic do_simple(input logic [7:0] op);
    logic [7:0] rx;
    ss_low();
    xfer(op, rx);
    repeat (SYNC + 2) @(negedge clk);
    check("simple_cmd_oe", {31'd0, spi_sdo_oe}, 32'd0);
    if (op == 8'h06) wel_m = 1'b1;
    if (op == 8'h04) wel_m = 1'b0;
    ss_high();
  endtask

  task automatic do_read(input logic [15:0] a, input int n);
    logic [7:0] rx;
    logic [15:0] ea;
    ss_low();
    xfer(8'h03, rx);
    for (int i = 0; i <= n; i++) exp_rd_q.push_back(16'(a + i));
    send_addr({8'h00, a});
    check("read_oe", {31'd0, spi_sdo_oe}, 32'd1);
    for (int i = 0; i < n; i++) begin
      xfer(8'h00, rx);
      last_rx.push_back(rx);
      ea = 16'(a + i);
      check("read_byte", {24'd0, rx}, {24'd0, ref_mem[ea]});
    end
    ss_high();
  endtask

  task automatic do_prog(input logic [15:0] a, input logic [15:0] data, input int n, input int extra_bits);
    logic [7:0] rx;
    logic r;
    ss_low();
    xfer(8'h02, rx);
    if (wel_m) begin
      for (int i = 0; i < n; i++) begin
        exp_wr_q.push_back({16'(a + i), (i == 0) ? data[15:8] : data[7:0]});
        ref_mem[16'(a + i)] = (i == 0) ? data[15:8] : data[7:0];
      end
    end
    send_addr({8'h00, a});
    xfer(data[15:8], rx);
    if (n > 1) xfer(data[7:0], rx);
    for (int i = 0; i < extra_bits; i++) spi_bit(1'b1, r);
    ss_high();
    wel_m = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] rx;
    logic r;
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'(i * 7 + 3);
      ref_mem[i] = mem[i];
    end
    mem[16'h0010] = 8'hA5; ref_mem[16'h0010] = 8'hA5;
    mem[16'h0011] = 8'h5A; ref_mem[16'h0011] = 8'h5A;
    wel_m = 1'b0;

    repeat (6) @(negedge clk);
    preset = 1'b0;
    @(negedge clk);
    check("rst_sdo", {31'd0, spi_sdo}, 32'd0);
    check("rst_oe", {31'd0, spi_sdo_oe}, 32'd0);
    check("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    check("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
    chk_en = 1'b1;
    repeat (4) @(negedge clk);

    // JEDEC id
    do_id();
    check("id_lit0", {24'd0, last_rx[0]}, 32'hBF);
    check("id_lit1", {24'd0, last_rx[1]}, 32'h25);
    check("id_lit2", {24'd0, last_rx[2]}, 32'h41);

    // Read with prefetch
    do_read(16'h0010, 2);
    check("read_lit0", {24'd0, last_rx[0]}, 32'hA5);
    check("read_lit1", {24'd0, last_rx[1]}, 32'h5A);

    // Write enable, status, program across the address wrap, partial byte dropped
    do_simple(8'h06);
    do_status(2);
    check("status_wel_lit", {24'd0, last_rx[0]}, 32'h02);
    check("status_repeat_lit", {24'd0, last_rx[1]}, 32'h02);
    do_prog(16'hFFFF, 16'h1122, 2, 3);
    do_status(1);
    check("status_after_prog_lit", {24'd0, last_rx[0]}, 32'h00);
    do_read(16'hFFFF, 2);
    check("wrap_read_lit0", {24'd0, last_rx[0]}, 32'h11);
    check("wrap_read_lit1", {24'd0, last_rx[1]}, 32'h22);

    // Program without write enable
    do_prog(16'h0100, 16'h7700, 1, 0);
    do_status(1);
    check("status_no_wel_lit", {24'd0, last_rx[0]}, 32'h00);

    // Write disable and unknown opcode
    do_simple(8'h06);
    do_simple(8'h04);
    do_simple(8'hAB);
    do_status(1);

    // Read aborted three bits into the first data byte
    ss_low();
    xfer(8'h03, rx);
    exp_rd_q.push_back(16'h0020);
    send_addr(24'h000020);
    for (int i = 0; i < 3; i++) spi_bit(1'b0, r);
    ss_high();
    do_id();

    // Reset in the middle of a read with SS held low
    do_simple(8'h06);
    ss_low();
    xfer(8'h03, rx);
    exp_rd_q.push_back(16'h0030);
    send_addr(24'h000030);
    for (int i = 0; i < 2; i++) spi_bit(1'b0, r);
    preset = 1'b1;
    @(negedge clk);
    check("mid_rst_oe", {31'd0, spi_sdo_oe}, 32'd0);
    check("mid_rst_sdo", {31'd0, spi_sdo}, 32'd0);
    check("mid_rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    check("mid_rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    check("mid_rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    check("mid_rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
    preset = 1'b0;
    wel_m = 1'b0;
    for (int i = 0; i < 14; i++) spi_bit(1'b0, r);
    check("ignored_frame_oe", {31'd0, spi_sdo_oe}, 32'd0);
    ss_high();
    do_status(1);
    check("status_after_rst_lit", {24'd0, last_rx[0]}, 32'h00);

    repeat (10) @(negedge clk);
    check("rd_queue_drained", exp_rd_q.size(), 32'd0);
    check("wr_queue_drained", exp_wr_q.size(), 32'd0);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
